// File: rtl/morning_java_pkg.sv
// Shared constants and state encodings for the morning_java serial sqrt project.
package morning_java_pkg;
  localparam logic [7:0] PROJECT_ID = 8'h01;
  localparam int         NREG       = 8;
  localparam int         SQRT_STEPS = 8;

  localparam logic [2:0] R_DAC_LO = 3'd4;
  localparam logic [2:0] R_DAC_HI = 3'd5;
  localparam logic [2:0] R_TRIG   = 3'd7;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/morning_java_uart_rx.sv
// 1x-sampled UART receiver: one bit per clk, LSB first, tms captured with the stop bit.
module morning_java_uart_rx
  import morning_java_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tdi,
  input  logic       i_tms,
  output logic [7:0] o_byte,
  output logic       o_tms,
  output logic       o_valid
);
  rx_state_e  r_state, w_nxt;
  logic [2:0] r_cnt;
  logic [7:0] r_sh, r_byte;
  logic       r_tms, r_valid;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      RX_IDLE: if (!i_tdi) w_nxt = RX_DATA;
      RX_DATA: if (r_cnt == 3'd7) w_nxt = RX_STOP;
      RX_STOP: w_nxt = RX_IDLE;
      default: w_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_byte  <= '0;
      r_tms   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_valid <= 1'b0;
      case (r_state)
        RX_IDLE: r_cnt <= '0;
        RX_DATA: begin
          r_sh  <= {i_tdi, r_sh[7:1]};
          r_cnt <= r_cnt + 3'd1;
        end
        RX_STOP: if (i_tdi) begin
          // A low stop bit is a framing error; the byte is silently dropped.
          r_valid <= 1'b1;
          r_byte  <= r_sh;
          r_tms   <= i_tms;
        end
        default: ;
      endcase
    end
  end

  assign o_byte  = r_byte;
  assign o_tms   = r_tms;
  assign o_valid = r_valid;
endmodule

// File: rtl/morning_java_top.sv
// Serial-addressed register file driving a bit-serial 16-bit sqrt whose root is sent back over UART.
module morning_java_top
  import morning_java_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic w_clk, w_rst_n, w_mode, w_uart_clk, w_tck, w_tms, w_tdi, w_unused;
  assign w_clk      = io_in[0];
  assign w_rst_n    = io_in[1];
  assign w_unused   = io_in[2];
  assign w_mode     = io_in[3];
  assign w_uart_clk = io_in[4];
  assign w_tck      = io_in[5];
  assign w_tms      = io_in[6];
  assign w_tdi      = io_in[7];

  logic [7:0] w_rx_byte;
  logic       w_rx_tms, w_rx_valid;

  morning_java_uart_rx u_rx (
    .i_clk  (w_clk),
    .i_rst_n(w_rst_n),
    .i_tdi  (w_tdi),
    .i_tms  (w_tms),
    .o_byte (w_rx_byte),
    .o_tms  (w_rx_tms),
    .o_valid(w_rx_valid)
  );

  logic                 r_sel, r_busy;
  logic [NREG-1:0][3:0] r_regs;
  logic [2:0]           w_idx;
  logic                 w_wr, w_trig;

  assign w_idx  = w_rx_byte[6:4];
  assign w_wr   = w_rx_valid && w_rx_tms && r_sel;
  assign w_trig = w_wr && (w_idx == R_TRIG) && !r_busy;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sel  <= 1'b0;
      r_regs <= '0;
    end else begin
      if (w_rx_valid && !w_rx_tms) r_sel <= (w_rx_byte == PROJECT_ID);
      if (w_wr) r_regs[w_idx] <= w_rx_byte[3:0];
    end
  end

  // Restoring sqrt: each step pulls the next two radicand bits into the remainder.
  logic [15:0] r_x;
  logic [11:0] r_rem, w_sh, w_trial;
  logic [7:0]  r_root;
  logic [2:0]  r_sq_cnt;
  logic        r_sq_run, r_sq_done, w_ge;

  assign w_sh    = 12'({r_rem, r_x[15:14]});
  assign w_trial = {2'b00, r_root, 2'b01};
  assign w_ge    = (w_sh >= w_trial);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_x       <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_sq_cnt  <= '0;
      r_sq_run  <= 1'b0;
      r_sq_done <= 1'b0;
    end else begin
      r_sq_done <= 1'b0;
      if (w_trig) begin
        // Radicand uses R0..R3 as they stood before this R7 write.
        r_x      <= {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
        r_rem    <= '0;
        r_root   <= '0;
        r_sq_cnt <= '0;
        r_sq_run <= 1'b1;
      end else if (r_sq_run) begin
        r_x      <= {r_x[13:0], 2'b00};
        r_rem    <= w_ge ? (w_sh - w_trial) : w_sh;
        r_root   <= {r_root[6:0], w_ge};
        r_sq_cnt <= r_sq_cnt + 3'd1;
        if (r_sq_cnt == 3'(SQRT_STEPS - 1)) begin
          r_sq_run  <= 1'b0;
          r_sq_done <= 1'b1;
        end
      end
    end
  end

  tx_state_e  r_tx_state, w_tx_nxt;
  logic [7:0] r_tx_sh;
  logic [2:0] r_tx_cnt;
  logic       w_tdo;

  always_comb begin
    w_tx_nxt = r_tx_state;
    w_tdo    = 1'b1;
    case (r_tx_state)
      TX_IDLE:  if (r_sq_done) w_tx_nxt = TX_START;
      TX_START: begin
        w_tdo    = 1'b0;
        w_tx_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tdo = r_tx_sh[0];
        if (r_tx_cnt == 3'd7) w_tx_nxt = TX_STOP;
      end
      TX_STOP:  w_tx_nxt = TX_IDLE;
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_sh    <= '0;
      r_tx_cnt   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_nxt;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_sh  <= r_root;
          r_tx_cnt <= '0;
        end
        TX_DATA: begin
          r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
          r_tx_cnt <= r_tx_cnt + 3'd1;
        end
        default: ;
      endcase
      if (w_trig) r_busy <= 1'b1;
      else if (r_tx_state == TX_STOP) r_busy <= 1'b0;
    end
  end

  assign io_out[4:0] = {r_regs[R_DAC_HI][0], r_regs[R_DAC_LO]};
  assign io_out[5]   = w_mode ? w_uart_clk : w_tck;
  assign io_out[6]   = r_busy;
  assign io_out[7]   = w_tdo;
endmodule

// File: tb/tb_morning_java_top.sv
// Directed + randomized bench for morning_java_top against a behavioural register/sqrt model.
module tb_morning_java_top;
  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, uart_clk = 1'b0, tck = 1'b0;
  logic tms = 1'b0, tdi = 1'b1;
  logic [7:0] io_in, io_out;

  assign io_in = {tdi, tms, tck, uart_clk, mode, 1'b0, rst_n, clk};

  morning_java_top dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;

  // Behavioural model state
  logic [3:0]  m_reg [8];
  logic        m_sel, m_busy, m_trig;
  logic [15:0] m_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [15:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 8'(r);
  endfunction

  function automatic logic [4:0] m_dac();
    return {m_reg[5][0], m_reg[4]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 4'h0;
    m_sel = 1'b0; m_busy = 1'b0; m_trig = 1'b0; m_x = '0;
  endtask

  // Returns at the negedge after the clk that dispatches the byte.
  task automatic send(input logic [7:0] b, input logic t, input logic stop_ok);
    @(negedge clk); tms = t; tdi = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); tdi = b[i]; end
    @(negedge clk); tdi = stop_ok;
    @(negedge clk); tdi = 1'b1;
    @(negedge clk);
    m_trig = 1'b0;
    if (stop_ok) begin
      if (!t) m_sel = (b == 8'h01);
      else if (m_sel) begin
        if (b[6:4] == 3'd7 && !m_busy) begin
          m_trig = 1'b1;
          m_busy = 1'b1;
          m_x    = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
        end
        m_reg[b[6:4]] = b[3:0];
      end
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp);
    int n = 0;
    logic [7:0] got = '0;
    chk({tag, "_busy_rise"}, 32'(io_out[6]), 32'd1);
    while (io_out[7] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, 9);
    for (int i = 0; i < 8; i++) begin @(negedge clk); got[i] = io_out[7]; end
    chk({tag, "_data"}, 32'(got), 32'(exp));
    @(negedge clk);
    chk({tag, "_stop"}, 32'({io_out[7], io_out[6]}), 32'b11);
    @(negedge clk);
    chk({tag, "_busy_fall"}, 32'({io_out[7], io_out[6]}), 32'b10);
    m_busy = 1'b0;
  endtask

  task automatic load_and_run(input string tag, input logic [15:0] x);
    for (int i = 0; i < 4; i++) send({1'b0, 3'(i), x[4*i +: 4]}, 1'b1, 1'b1);
    send(8'h70, 1'b1, 1'b1);
    chk({tag, "_trig"}, 32'(m_trig), 32'd1);
    expect_frame(tag, isqrt(m_x));
  endtask

  initial begin
    int n;
    logic [15:0] rx;
    model_reset();

    // 1: reset state and rtck forwarding (also while in reset)
    #2;
    chk("rst_out", 32'({io_out[7:6], io_out[4:0]}), 32'b10_00000);
    for (int i = 0; i < 6; i++) begin
      mode = i[0]; uart_clk = 1'($urandom); tck = 1'($urandom); #1;
      chk("rtck_rst", 32'(io_out[5]), 32'(mode ? uart_clk : tck));
      if (i == 3) rst_n = 1'b1;
    end
    @(negedge clk);
    chk("idle_out", 32'({io_out[7:6], io_out[4:0]}), 32'b10_00000);

    // 3: address miss, then hit
    send(8'h02, 1'b0, 1'b1);
    send(8'h45, 1'b1, 1'b1);
    chk("miss_dac", 32'(io_out[4:0]), 32'(m_dac()));
    send(8'h01, 1'b0, 1'b1);
    send(8'h45, 1'b1, 1'b1);
    chk("hit_dac", 32'(io_out[4:0]), 32'(m_dac()));

    // 2: full sequence
    send(8'h01, 1'b0, 1'b1);
    foreach (m_reg[i]) ;
    send(8'h01, 1'b1, 1'b1); send(8'h10, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1); send(8'h30, 1'b1, 1'b1);
    send(8'h43, 1'b1, 1'b1);
    chk("seq_dac", 32'(io_out[4:0]), 32'(m_dac()));
    send(8'h50, 1'b1, 1'b1); send(8'h64, 1'b1, 1'b1);
    send(8'h70, 1'b1, 1'b1);
    chk("seq_x", 32'(m_x), 32'h0201);
    expect_frame("seq", 8'h16);

    // 4: framing error drops byte, next good byte accepted
    send(8'h4A, 1'b1, 1'b0);
    chk("frm_drop", 32'(io_out[4:0]), 32'(m_dac()));
    send(8'h4C, 1'b1, 1'b1);
    chk("frm_next", 32'(io_out[4:0]), 32'(m_dac()));

    // 5: boundaries
    load_and_run("xffff", 16'hFFFF);
    load_and_run("x0", 16'h0000);
    load_and_run("x16", 16'd16);

    // R7 write while busy: no second frame
    send(8'h70, 1'b1, 1'b1);
    send(8'h7A, 1'b1, 1'b1);
    chk("busy_no_retrig", 32'(m_trig), 32'd0);
    n = 0;
    while (io_out[6] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("busy_drop", 32'(io_out[6]), 32'd0);
    m_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (io_out[7] !== 1'b1 || io_out[6] !== 1'b0) n++;
    end
    chk("no_second_frame", n, 0);

    // Randomized radicands and DAC values
    for (int k = 0; k < 5; k++) begin
      rx = 16'($urandom);
      send({4'h4, 4'($urandom)}, 1'b1, 1'b1);
      send({4'h5, 4'($urandom)}, 1'b1, 1'b1);
      chk("rnd_dac", 32'(io_out[4:0]), 32'(m_dac()));
      load_and_run("rnd", rx);
    end

    // 6: reset mid-TX
    send(8'h70, 1'b1, 1'b1);
    n = 0;
    while (io_out[7] !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("mid_tx_start", 32'(io_out[7]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    model_reset();
    chk("mid_tx_rst", 32'({io_out[7:6], io_out[4:0]}), 32'({2'b10, m_dac()}));
    @(negedge clk); rst_n = 1'b1;
    send(8'h45, 1'b1, 1'b1);
    chk("post_rst_ignored", 32'(io_out[4:0]), 32'(m_dac()));
    send(8'h01, 1'b0, 1'b1);
    send(8'h45, 1'b1, 1'b1);
    chk("post_rst_readdr", 32'(io_out[4:0]), 32'(m_dac()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
